// File: rtl/uart_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_boot_loader
// Purpose  : Device-side firmware-load responder. Masters an iob_uart native
//            bus, runs the ENQ / ACK / FRX boot handshake, and stores a
//            length-prefixed file word by word into SRAM over a native
//            memory write port.
// Options  : UART_BOOT_LOADER_CKSUM_EN - after the file, receive a checksum
//            byte (sum of data bytes mod 256) and reply ACK or NAK.
// Revision : 1.0 - initial release
// ============================================================================
module uart_boot_loader #(
    parameter int DATA_W      = 32,
    parameter int MEM_ADDR_W  = 12,
    parameter int UART_DIV    = 16,
    parameter int ENQ_POLLS   = 1000,
    parameter int UART_ADDR_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   uart_valid,
    output logic [UART_ADDR_W-1:0] uart_addr,
    output logic [DATA_W-1:0]      uart_wdata,
    output logic [3:0]             uart_wstrb,
    input  logic [DATA_W-1:0]      uart_rdata,
    input  logic                   uart_ready,
    output logic                   mem_valid,
    output logic [MEM_ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    output logic [3:0]             mem_wstrb,
    input  logic                   mem_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   loaded,
    output logic                   error,
    output logic [31:0]            nbytes
);

    // iob_uart register map (word addresses)
    localparam logic [UART_ADDR_W-1:0] C_REG_SOFTRESET = UART_ADDR_W'(0);
    localparam logic [UART_ADDR_W-1:0] C_REG_DIV       = UART_ADDR_W'(1);
    localparam logic [UART_ADDR_W-1:0] C_REG_TXDATA    = UART_ADDR_W'(2);
    localparam logic [UART_ADDR_W-1:0] C_REG_TXEN      = UART_ADDR_W'(3);
    localparam logic [UART_ADDR_W-1:0] C_REG_TXREADY   = UART_ADDR_W'(4);
    localparam logic [UART_ADDR_W-1:0] C_REG_RXDATA    = UART_ADDR_W'(5);
    localparam logic [UART_ADDR_W-1:0] C_REG_RXEN      = UART_ADDR_W'(6);
    localparam logic [UART_ADDR_W-1:0] C_REG_RXREADY   = UART_ADDR_W'(7);

    localparam logic [7:0]        C_ENQ       = 8'h05;
    localparam logic [7:0]        C_ACK       = 8'h06;
    localparam logic [7:0]        C_FRX       = 8'h08;
    localparam logic [DATA_W-1:0] C_ONE       = DATA_W'(1);
    localparam logic [DATA_W-1:0] C_DIV_VAL   = DATA_W'(UART_DIV);
    localparam logic [31:0]       C_ENQ_POLLS = 32'(ENQ_POLLS);

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_INIT    = 4'd1;
    localparam logic [3:0] ST_TXPOLL  = 4'd2;
    localparam logic [3:0] ST_SENDENQ = 4'd3;
    localparam logic [3:0] ST_RXPOLL  = 4'd4;
    localparam logic [3:0] ST_RXREAD  = 4'd5;
    localparam logic [3:0] ST_SIZE    = 4'd6;
    localparam logic [3:0] ST_DATA    = 4'd7;
    localparam logic [3:0] ST_MEMWR   = 4'd8;
    localparam logic [3:0] ST_DONE    = 4'd9;
`ifdef UART_BOOT_LOADER_CKSUM_EN
    localparam logic [3:0] ST_CKSUM   = 4'd10;
    localparam logic [3:0] ST_RPOLL   = 4'd11;
    localparam logic [3:0] ST_REPLY   = 4'd12;
    localparam logic [7:0] C_NAK      = 8'h15;
`endif

    logic [3:0]             state_q, state_d;
    logic                   sub_q, sub_d;          // 0: poll RXREADY, 1: read RXDATA
    logic [2:0]             idx_q, idx_d;          // INIT step / SIZE byte index
    logic [31:0]            poll_cnt_q, poll_cnt_d;
    logic [31:0]            byte_cnt_q, byte_cnt_d;
    logic                   uart_valid_q, uart_valid_d;
    logic [UART_ADDR_W-1:0] uart_addr_q, uart_addr_d;
    logic [DATA_W-1:0]      uart_wdata_q, uart_wdata_d;
    logic [3:0]             uart_wstrb_q, uart_wstrb_d;
    logic                   mem_valid_q, mem_valid_d;
    logic [MEM_ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;  // also the word assembly buffer
    logic [3:0]             mem_wstrb_q, mem_wstrb_d;
    logic                   done_q, done_d;
    logic                   loaded_q, loaded_d;
    logic                   error_q, error_d;
    logic [31:0]            nbytes_q, nbytes_d;
`ifdef UART_BOOT_LOADER_CKSUM_EN
    logic [7:0]             sum_q, sum_d;
    logic [7:0]             reply_q, reply_d;
`endif

    logic                   w_fire;
    logic [7:0]             w_rx_byte;
    logic                   w_rx_flag;
    logic                   w_in_range;
    logic                   w_last;
    logic [1:0]             w_lane;
    logic [31:0]            w_size_next;
    logic                   w_unused_rdata;

    assign w_fire         = uart_valid_q & uart_ready;
    assign w_rx_byte      = uart_rdata[7:0];
    assign w_rx_flag      = uart_rdata[0];
    assign w_in_range     = (byte_cnt_q[31:MEM_ADDR_W+2] == '0);
    assign w_last         = ((byte_cnt_q + 32'd1) == nbytes_q);
    assign w_lane         = byte_cnt_q[1:0];
    assign w_size_next    = {w_rx_byte, nbytes_q[31:8]};
    assign w_unused_rdata = ^uart_rdata[DATA_W-1:8];

    // Next-state logic: request selection for the uart bus plus FSM transitions
    always_comb begin
        logic                   req_en;
        logic [UART_ADDR_W-1:0] req_addr;
        logic [DATA_W-1:0]      req_wdata;
        logic [3:0]             req_wstrb;

        state_d      = state_q;
        sub_d        = sub_q;
        idx_d        = idx_q;
        poll_cnt_d   = poll_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        uart_valid_d = uart_valid_q;
        uart_addr_d  = uart_addr_q;
        uart_wdata_d = uart_wdata_q;
        uart_wstrb_d = uart_wstrb_q;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        done_d       = done_q;
        loaded_d     = loaded_q;
        error_d      = error_q;
        nbytes_d     = nbytes_q;
`ifdef UART_BOOT_LOADER_CKSUM_EN
        sum_d        = sum_q;
        reply_d      = reply_q;
`endif
        req_en       = 1'b0;
        req_addr     = C_REG_SOFTRESET;
        req_wdata    = '0;
        req_wstrb    = 4'h0;

        // Which uart access the current state needs (reads carry wstrb=0)
        case (state_q)
            ST_INIT: begin
                req_en    = 1'b1;
                req_wstrb = 4'hF;
                case (idx_q)
                    3'd0:    begin req_addr = C_REG_SOFTRESET; req_wdata = C_ONE;     end
                    3'd1:    begin req_addr = C_REG_SOFTRESET; req_wdata = '0;        end
                    3'd2:    begin req_addr = C_REG_DIV;       req_wdata = C_DIV_VAL; end
                    3'd3:    begin req_addr = C_REG_TXEN;      req_wdata = C_ONE;     end
                    default: begin req_addr = C_REG_RXEN;      req_wdata = C_ONE;     end
                endcase
            end
            ST_TXPOLL: begin req_en = 1'b1; req_addr = C_REG_TXREADY; end
            ST_SENDENQ: begin
                req_en    = 1'b1;
                req_addr  = C_REG_TXDATA;
                req_wdata = DATA_W'(C_ENQ);
                req_wstrb = 4'hF;
            end
            ST_RXPOLL: begin req_en = 1'b1; req_addr = C_REG_RXREADY; end
            ST_RXREAD: begin req_en = 1'b1; req_addr = C_REG_RXDATA;  end
`ifdef UART_BOOT_LOADER_CKSUM_EN
            ST_RPOLL:  begin req_en = 1'b1; req_addr = C_REG_TXREADY; end
            ST_REPLY: begin
                req_en    = 1'b1;
                req_addr  = C_REG_TXDATA;
                req_wdata = DATA_W'(reply_q);
                req_wstrb = 4'hF;
            end
            ST_CKSUM,
`endif
            ST_SIZE, ST_DATA: begin
                req_en   = 1'b1;
                req_addr = sub_q ? C_REG_RXDATA : C_REG_RXREADY;
            end
            default: req_en = 1'b0;
        endcase

        // Launch a request only when none is outstanding; drop valid after ready
        if (req_en && !uart_valid_q) begin
            uart_valid_d = 1'b1;
            uart_addr_d  = req_addr;
            uart_wdata_d = req_wdata;
            uart_wstrb_d = req_wstrb;
        end
        if (w_fire) begin
            uart_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    done_d      = 1'b0;
                    loaded_d    = 1'b0;
                    error_d     = 1'b0;
                    nbytes_d    = '0;
                    idx_d       = '0;
                    sub_d       = 1'b0;
                    poll_cnt_d  = '0;
                    byte_cnt_d  = '0;
                    mem_wdata_d = '0;
                    mem_wstrb_d = 4'h0;
`ifdef UART_BOOT_LOADER_CKSUM_EN
                    sum_d       = '0;
`endif
                    state_d     = ST_INIT;
                end
            end
            ST_INIT: begin
                if (w_fire) begin
                    if (idx_q == 3'd4) begin
                        idx_d   = '0;
                        state_d = ST_TXPOLL;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_TXPOLL: begin
                if (w_fire && w_rx_flag) state_d = ST_SENDENQ;
            end
            ST_SENDENQ: begin
                if (w_fire) state_d = ST_RXPOLL;
            end
            ST_RXPOLL: begin
                if (w_fire) begin
                    if (w_rx_flag) begin
                        state_d = ST_RXREAD;
                    end else if ((poll_cnt_q + 32'd1) == C_ENQ_POLLS) begin
                        // host stayed silent for a full window: resend ENQ
                        poll_cnt_d = '0;
                        state_d    = ST_TXPOLL;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 32'd1;
                    end
                end
            end
            ST_RXREAD: begin
                if (w_fire) begin
                    if (w_rx_byte == C_ACK) begin
                        state_d = ST_DONE;
                    end else if (w_rx_byte == C_FRX) begin
                        sub_d   = 1'b0;
                        idx_d   = '0;
                        state_d = ST_SIZE;
                    end else begin
                        state_d = ST_RXPOLL;
                    end
                end
            end
            ST_SIZE: begin
                if (w_fire) begin
                    if (!sub_q) begin
                        sub_d = w_rx_flag;
                    end else begin
                        sub_d    = 1'b0;
                        nbytes_d = w_size_next;
                        if (idx_q == 3'd3) begin
                            byte_cnt_d = '0;
                            if (w_size_next == '0) begin
                                loaded_d = 1'b1;
                                state_d  = ST_DONE;
                            end else begin
                                state_d  = ST_DATA;
                            end
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (w_fire) begin
                    if (!sub_q) begin
                        sub_d = w_rx_flag;
                    end else begin
                        sub_d      = 1'b0;
                        byte_cnt_d = byte_cnt_q + 32'd1;
`ifdef UART_BOOT_LOADER_CKSUM_EN
                        sum_d      = sum_q + w_rx_byte;
`endif
                        if (w_last) loaded_d = 1'b1;
                        if (w_in_range) begin
                            mem_wdata_d[{w_lane, 3'b000} +: 8] = w_rx_byte;
                            mem_wstrb_d[w_lane]                = 1'b1;
                            mem_addr_d = byte_cnt_q[MEM_ADDR_W+1:2];
                            if (w_lane == 2'd3 || w_last) state_d = ST_MEMWR;
                        end else begin
                            // beyond SRAM: swallow the byte and flag overflow
                            error_d = 1'b1;
                            if (w_last) begin
`ifdef UART_BOOT_LOADER_CKSUM_EN
                                state_d = ST_CKSUM;
`else
                                state_d = ST_DONE;
`endif
                            end
                        end
                    end
                end
            end
            ST_MEMWR: begin
                if (!mem_valid_q) begin
                    mem_valid_d = 1'b1;
                end else if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    mem_wdata_d = '0;
                    mem_wstrb_d = 4'h0;
                    if (byte_cnt_q == nbytes_q) begin
`ifdef UART_BOOT_LOADER_CKSUM_EN
                        state_d = ST_CKSUM;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
`ifdef UART_BOOT_LOADER_CKSUM_EN
            ST_CKSUM: begin
                if (w_fire) begin
                    if (!sub_q) begin
                        sub_d = w_rx_flag;
                    end else begin
                        sub_d = 1'b0;
                        if (w_rx_byte == sum_q) begin
                            reply_d = C_ACK;
                        end else begin
                            reply_d = C_NAK;
                            error_d = 1'b1;
                        end
                        state_d = ST_RPOLL;
                    end
                end
            end
            ST_RPOLL: begin
                if (w_fire && w_rx_flag) state_d = ST_REPLY;
            end
            ST_REPLY: begin
                if (w_fire) state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sub_q        <= 1'b0;
            idx_q        <= '0;
            poll_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            uart_valid_q <= 1'b0;
            uart_addr_q  <= '0;
            uart_wdata_q <= '0;
            uart_wstrb_q <= 4'h0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= 4'h0;
            done_q       <= 1'b0;
            loaded_q     <= 1'b0;
            error_q      <= 1'b0;
            nbytes_q     <= '0;
`ifdef UART_BOOT_LOADER_CKSUM_EN
            sum_q        <= '0;
            reply_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            sub_q        <= sub_d;
            idx_q        <= idx_d;
            poll_cnt_q   <= poll_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            uart_valid_q <= uart_valid_d;
            uart_addr_q  <= uart_addr_d;
            uart_wdata_q <= uart_wdata_d;
            uart_wstrb_q <= uart_wstrb_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            done_q       <= done_d;
            loaded_q     <= loaded_d;
            error_q      <= error_d;
            nbytes_q     <= nbytes_d;
`ifdef UART_BOOT_LOADER_CKSUM_EN
            sum_q        <= sum_d;
            reply_q      <= reply_d;
`endif
        end
    end

    assign uart_valid = uart_valid_q;
    assign uart_addr  = uart_addr_q;
    assign uart_wdata = uart_wdata_q;
    assign uart_wstrb = uart_wstrb_q;
    assign mem_valid  = mem_valid_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done       = done_q;
    assign loaded     = loaded_q;
    assign error      = error_q;
    assign nbytes     = nbytes_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_boot_loader
// Purpose  : Directed self-checking bench for uart_boot_loader. A host model
//            answers uart register accesses from a byte queue; a memory model
//            logs writes with programmable ready latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_boot_loader;

    localparam int MEM_ADDR_W  = 2;
    localparam int UART_ADDR_W = 3;
    localparam int ENQ_POLLS   = 4;
    localparam int MAX_CYC     = 3000;

    localparam logic [2:0] A_SOFTRESET = 3'd0;
    localparam logic [2:0] A_DIV       = 3'd1;
    localparam logic [2:0] A_TXDATA    = 3'd2;
    localparam logic [2:0] A_TXEN      = 3'd3;
    localparam logic [2:0] A_TXREADY   = 3'd4;
    localparam logic [2:0] A_RXDATA    = 3'd5;
    localparam logic [2:0] A_RXEN      = 3'd6;
    localparam logic [2:0] A_RXREADY   = 3'd7;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic                   uart_valid;
    logic [UART_ADDR_W-1:0] uart_addr;
    logic [31:0]            uart_wdata;
    logic [3:0]             uart_wstrb;
    logic [31:0]            uart_rdata = '0;
    logic                   uart_ready = 1'b0;
    logic                   mem_valid;
    logic [MEM_ADDR_W-1:0]  mem_addr;
    logic [31:0]            mem_wdata;
    logic [3:0]             mem_wstrb;
    logic                   mem_ready = 1'b0;
    logic                   busy, done, loaded, error;
    logic [31:0]            nbytes;

    int checks   = 0;
    int failures = 0;

    // host / memory model state
    logic [7:0]  host_rx[$];
    int          silent = 0;
    logic [2:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    logic [1:0]  ml_addr[$];
    logic [31:0] ml_data[$];
    logic [3:0]  ml_strb[$];
    int          mem_delay = 0;
    int          mem_cnt = 0;
    bit          mem_busy = 0;
    bit          mem_bad = 0;
    logic [1:0]  cap_addr;
    logic [31:0] cap_data;
    logic [3:0]  cap_strb;

    uart_boot_loader #(
        .DATA_W(32), .MEM_ADDR_W(MEM_ADDR_W), .UART_DIV(16),
        .ENQ_POLLS(ENQ_POLLS), .UART_ADDR_W(UART_ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .uart_valid(uart_valid), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
        .uart_wstrb(uart_wstrb), .uart_rdata(uart_rdata), .uart_ready(uart_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .busy(busy), .done(done), .loaded(loaded), .error(error), .nbytes(nbytes)
    );

    always #5 clk = ~clk;

    // Host console: one-cycle ready, rdata valid in the ready cycle
    always @(negedge clk) begin
        if (rst) begin
            uart_ready = 1'b0;
        end else if (uart_ready) begin
            uart_ready = 1'b0;
        end else if (uart_valid) begin
            uart_ready = 1'b1;
            uart_rdata = '0;
            if (uart_wstrb != 4'h0) begin
                wr_addr.push_back(uart_addr);
                wr_data.push_back(uart_wdata);
            end else begin
                case (uart_addr)
                    A_TXREADY: uart_rdata = 32'd1;
                    A_RXREADY: begin
                        if (silent > 0) silent = silent - 1;
                        else uart_rdata = {31'd0, host_rx.size() != 0};
                    end
                    A_RXDATA: if (host_rx.size() != 0) uart_rdata = {24'd0, host_rx.pop_front()};
                    default: uart_rdata = '0;
                endcase
            end
        end
    end

    // SRAM model: ready after mem_delay cycles; flags any change while waiting
    always @(negedge clk) begin
        if (rst) begin
            mem_ready = 1'b0;
            mem_busy  = 0;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
            mem_busy  = 0;
        end else if (mem_valid) begin
            if (!mem_busy) begin
                mem_busy = 1;
                cap_addr = mem_addr;
                cap_data = mem_wdata;
                cap_strb = mem_wstrb;
                mem_cnt  = mem_delay;
            end else if (mem_addr !== cap_addr || mem_wdata !== cap_data || mem_wstrb !== cap_strb) begin
                mem_bad = 1;
            end
            if (mem_cnt == 0) begin
                mem_ready = 1'b1;
                ml_addr.push_back(mem_addr);
                ml_data.push_back(mem_wdata);
                ml_strb.push_back(mem_wstrb);
            end else begin
                mem_cnt = mem_cnt - 1;
            end
        end else if (mem_busy) begin
            mem_bad = 1;  // valid withdrawn before ready
        end
    end

    task automatic clear_host();
        host_rx.delete(); wr_addr.delete(); wr_data.delete();
        ml_addr.delete(); ml_data.delete(); ml_strb.delete();
        silent = 0; mem_delay = 0; mem_bad = 0;
    endtask

    task automatic run_session(output bit ok);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        ok = 0;
        for (int i = 0; i < MAX_CYC; i++) begin
            if (done === 1'b1 && busy === 1'b0) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask

    // push FRX, length and data; returns sum of data bytes mod 256
    task automatic push_file(input logic [7:0] first, input int len, input logic [7:0] step,
                             output logic [7:0] sum);
        logic [31:0] l;
        logic [7:0]  b;
        l = 32'(len);
        sum = '0;
        host_rx.push_back(8'h08);
        for (int i = 0; i < 4; i++) host_rx.push_back(l[8*i +: 8]);
        b = first;
        for (int i = 0; i < len; i++) begin
            host_rx.push_back(b);
            sum = sum + b;
            b = b + step;
        end
`ifdef UART_BOOT_LOADER_CKSUM_EN
        host_rx.push_back(sum);
`endif
    endtask

    function automatic int count_enq();
        int n = 0;
        for (int i = 0; i < wr_addr.size(); i++)
            if (wr_addr[i] == A_TXDATA && wr_data[i] == 32'h05) n++;
        return n;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({uart_valid, uart_wstrb, uart_addr, uart_wdata} !== '0) begin failures++;
            $display("FAIL reset_uart got valid=%b addr=%0d wdata=%h wstrb=%h want all 0", uart_valid, uart_addr, uart_wdata, uart_wstrb); end
        checks++; if ({mem_valid, mem_addr, mem_wdata, mem_wstrb} !== '0) begin failures++;
            $display("FAIL reset_mem got valid=%b addr=%0d wdata=%h wstrb=%h want all 0", mem_valid, mem_addr, mem_wdata, mem_wstrb); end
        checks++; if ({busy, done, loaded, error, nbytes} !== '0) begin failures++;
            $display("FAIL reset_status got busy=%b done=%b loaded=%b error=%b nbytes=%0d want all 0", busy, done, loaded, error, nbytes); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ack();
        logic [2:0]  ea[6] = '{A_SOFTRESET, A_SOFTRESET, A_DIV, A_TXEN, A_RXEN, A_TXDATA};
        logic [31:0] ed[6] = '{32'd1, 32'd0, 32'd16, 32'd1, 32'd1, 32'h05};
        bit ok;
        clear_host();
        host_rx.push_back(8'h06);
        run_session(ok);
        checks++; if (!ok) begin failures++; $display("FAIL ack_timeout got done=%b want 1", done); end
        checks++; if (wr_addr.size() != 6) begin failures++;
            $display("FAIL ack_write_count got %0d want 6", wr_addr.size()); end
        if (wr_addr.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                checks++; if (wr_addr[i] !== ea[i] || wr_data[i] !== ed[i]) begin failures++;
                    $display("FAIL ack_write%0d got addr=%0d data=%h want addr=%0d data=%h", i, wr_addr[i], wr_data[i], ea[i], ed[i]); end
            end
        end
        checks++; if (loaded !== 1'b0 || error !== 1'b0 || ml_addr.size() != 0) begin failures++;
            $display("FAIL ack_status got loaded=%b error=%b memwr=%0d want 0 0 0", loaded, error, ml_addr.size()); end
    endtask

    task automatic test_enq_retry();
        logic [7:0] s;
        bit ok;
        clear_host();
        silent = 10;
        push_file(8'h11, 8, 8'h11, s);
        run_session(ok);
        checks++; if (!ok) begin failures++; $display("FAIL retry_timeout got done=%b want 1", done); end
        checks++; if (count_enq() != 3) begin failures++;
            $display("FAIL retry_enq_count got %0d want 3", count_enq()); end
        checks++; if (ml_addr.size() != 2) begin failures++;
            $display("FAIL retry_memwr_count got %0d want 2", ml_addr.size()); end
        if (ml_addr.size() == 2) begin
            checks++; if (ml_addr[0] !== 2'd0 || ml_data[0] !== 32'h44332211 || ml_strb[0] !== 4'hF) begin failures++;
                $display("FAIL retry_word0 got addr=%0d data=%h strb=%h want 0 44332211 f", ml_addr[0], ml_data[0], ml_strb[0]); end
            checks++; if (ml_addr[1] !== 2'd1 || ml_data[1] !== 32'h88776655 || ml_strb[1] !== 4'hF) begin failures++;
                $display("FAIL retry_word1 got addr=%0d data=%h strb=%h want 1 88776655 f", ml_addr[1], ml_data[1], ml_strb[1]); end
        end
        checks++; if (loaded !== 1'b1 || nbytes !== 32'd8 || error !== 1'b0) begin failures++;
            $display("FAIL retry_status got loaded=%b nbytes=%0d error=%b want 1 8 0", loaded, nbytes, error); end
    endtask

    task automatic test_partial_word();
        logic [7:0] s;
        bit ok;
        clear_host();
        mem_delay = 3;
        push_file(8'h01, 5, 8'h01, s);
        run_session(ok);
        checks++; if (!ok) begin failures++; $display("FAIL partial_timeout got done=%b want 1", done); end
        checks++; if (ml_addr.size() != 2) begin failures++;
            $display("FAIL partial_memwr_count got %0d want 2", ml_addr.size()); end
        if (ml_addr.size() == 2) begin
            checks++; if (ml_data[0] !== 32'h04030201 || ml_strb[0] !== 4'hF) begin failures++;
                $display("FAIL partial_word0 got data=%h strb=%h want 04030201 f", ml_data[0], ml_strb[0]); end
            checks++; if (ml_addr[1] !== 2'd1 || ml_data[1][7:0] !== 8'h05 || ml_strb[1] !== 4'h1) begin failures++;
                $display("FAIL partial_word1 got addr=%0d byte=%h strb=%h want 1 05 1", ml_addr[1], ml_data[1][7:0], ml_strb[1]); end
        end
        checks++; if (mem_bad !== 1'b0) begin failures++;
            $display("FAIL partial_hold got unstable=%b want 0", mem_bad); end
        checks++; if (nbytes !== 32'd5 || loaded !== 1'b1) begin failures++;
            $display("FAIL partial_status got nbytes=%0d loaded=%b want 5 1", nbytes, loaded); end
    endtask

    task automatic test_overflow();
        logic [7:0] s;
        bit ok;
        clear_host();
        push_file(8'h01, 18, 8'h01, s);
        run_session(ok);
        checks++; if (!ok) begin failures++; $display("FAIL ovf_timeout got done=%b want 1", done); end
        checks++; if (ml_addr.size() != 4) begin failures++;
            $display("FAIL ovf_memwr_count got %0d want 4", ml_addr.size()); end
        if (ml_addr.size() == 4) begin
            checks++; if (ml_addr[3] !== 2'd3 || ml_data[3] !== 32'h100F0E0D || ml_strb[3] !== 4'hF) begin failures++;
                $display("FAIL ovf_last_word got addr=%0d data=%h strb=%h want 3 100f0e0d f", ml_addr[3], ml_data[3], ml_strb[3]); end
        end
        checks++; if (error !== 1'b1 || loaded !== 1'b1 || nbytes !== 32'd18) begin failures++;
            $display("FAIL ovf_status got error=%b loaded=%b nbytes=%0d want 1 1 18", error, loaded, nbytes); end
    endtask

    task automatic test_junk_size0();
        logic [7:0] s;
        bit ok;
        clear_host();
        host_rx.push_back(8'h41);
        push_file(8'h00, 0, 8'h00, s);
`ifdef UART_BOOT_LOADER_CKSUM_EN
        void'(host_rx.pop_back());  // empty file carries no checksum byte
`endif
        run_session(ok);
        checks++; if (!ok) begin failures++; $display("FAIL junk_timeout got done=%b want 1", done); end
        checks++; if (loaded !== 1'b1 || nbytes !== 32'd0 || error !== 1'b0) begin failures++;
            $display("FAIL junk_status got loaded=%b nbytes=%0d error=%b want 1 0 0", loaded, nbytes, error); end
        checks++; if (ml_addr.size() != 0 || count_enq() != 1) begin failures++;
            $display("FAIL junk_traffic got memwr=%0d enq=%0d want 0 1", ml_addr.size(), count_enq()); end
    endtask

    task automatic test_rst_mid();
        logic [7:0] s;
        bit ok;
        bit seen = 0;
        clear_host();
        mem_delay = 50;
        push_file(8'hA0, 8, 8'h01, s);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < MAX_CYC; i++) begin
            if (mem_valid === 1'b1) begin seen = 1; break; end
            @(negedge clk);
        end
        checks++; if (!seen) begin failures++; $display("FAIL rst_mid_reach got mem_valid=%b want 1", mem_valid); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({uart_valid, mem_valid, busy, done, loaded, error, nbytes, mem_wstrb, uart_wstrb} !== '0) begin failures++;
            $display("FAIL rst_mid_outputs got uvalid=%b mvalid=%b busy=%b nbytes=%0d want all 0", uart_valid, mem_valid, busy, nbytes); end
        rst = 1'b0;
        clear_host();
        host_rx.push_back(8'h06);
        run_session(ok);
        checks++; if (!ok || wr_addr.size() != 6) begin failures++;
            $display("FAIL rst_mid_restart got ok=%b writes=%0d want 1 6", ok, wr_addr.size()); end
        if (wr_addr.size() == 6) begin
            checks++; if (wr_addr[0] !== A_SOFTRESET || wr_data[0] !== 32'd1 || wr_addr[4] !== A_RXEN) begin failures++;
                $display("FAIL rst_mid_init got first=%0d/%h fifth=%0d want 0/1 6", wr_addr[0], wr_data[0], wr_addr[4]); end
        end
    endtask

`ifdef UART_BOOT_LOADER_CKSUM_EN
    task automatic test_cksum();
        logic [7:0] s;
        bit ok;
        clear_host();
        push_file(8'h10, 2, 8'h10, s);
        run_session(ok);
        checks++; if (!ok || wr_data.size() == 0 || wr_addr[$] !== A_TXDATA || wr_data[$] !== 32'h06 || error !== 1'b0) begin failures++;
            $display("FAIL cksum_good got ok=%b error=%b want ACK reply and error 0", ok, error); end
        clear_host();
        push_file(8'h10, 2, 8'h10, s);
        void'(host_rx.pop_back());
        host_rx.push_back(8'h31);
        run_session(ok);
        checks++; if (!ok || wr_data.size() == 0 || wr_addr[$] !== A_TXDATA || wr_data[$] !== 32'h15 || error !== 1'b1) begin failures++;
            $display("FAIL cksum_bad got ok=%b error=%b want NAK reply and error 1", ok, error); end
    endtask
`endif

    initial begin
        test_reset();
        test_ack();
        test_enq_retry();
        test_partial_word();
        test_overflow();
        test_junk_size0();
        test_rst_mid();
`ifdef UART_BOOT_LOADER_CKSUM_EN
        test_cksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
